// File: rtl/mux_stream_rr_pkg.sv
// Shared constants, types and helpers for the round-robin stream multiplexer.
package mux_stream_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_SEL_W = 2;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Smallest w such that 2**w >= n; used to validate the select width.
    function automatic int clog2_fn(input int n);
        int w;
        w = 0;
        while ((32'sd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_stream_rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr+1, ptr+2, ... modulo N_CH.
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             enable,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic found_s;
    int   cand_s;

    // First requester after the pointer wins; nothing is granted while disabled.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        cand_s    = 0;
        for (int k = 1; k <= N_CH; k++) begin
            cand_s = (int'(ptr) + k) % N_CH;
            if (enable && !found_s && req[cand_s]) begin
                found_s        = 1'b1;
                grant[cand_s]  = 1'b1;
                grant_idx      = SEL_W'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mux_stream_rr.sv
// N-channel valid/ready stream multiplexer with fixed-select or round-robin
// arbitration feeding a single registered output slot.
module mux_stream_rr
    import mux_stream_rr_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    if (N_CH < 2 || SEL_W != clog2_fn(N_CH)) begin : g_bad_params
        $error("mux_stream_rr: N_CH must be >= 2 and SEL_W must equal ceil(log2(N_CH))");
    end

    slot_state_t      slot_r;
    logic [WIDTH-1:0] out_data_r;
    logic [SEL_W-1:0] out_ch_r;
    logic [SEL_W-1:0] last_grant_r;

    logic             accept_s;
    logic             sel_ok_s;
    logic             rr_en_s;
    logic [N_CH-1:0]  rr_grant_s;
    logic [SEL_W-1:0] rr_idx_s;
    logic [N_CH-1:0]  fix_grant_s;
    logic [N_CH-1:0]  grant_s;
    logic [SEL_W-1:0] grant_idx_s;
    logic             grant_any_s;

    assign accept_s = (slot_r == SLOT_EMPTY) | out_ready;
    assign sel_ok_s = (32'(sel) < N_CH);
    assign rr_en_s  = accept_s & (mode == MODE_RR) & ~rst;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (last_grant_r),
        .enable    (rr_en_s),
        .grant     (rr_grant_s),
        .grant_idx (rr_idx_s)
    );

    // Fixed-select grant; an out-of-range sel never grants.
    always_comb begin
        fix_grant_s = '0;
        if (!rst && accept_s && (mode == MODE_FIXED) && sel_ok_s) begin
            if (in_valid[sel]) begin
                fix_grant_s[sel] = 1'b1;
            end else begin
                fix_grant_s = '0;
            end
        end else begin
            fix_grant_s = '0;
        end
    end

    // Merge the two grant sources according to the current mode.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        if (mode == MODE_RR) begin
            grant_s     = rr_grant_s;
            grant_idx_s = rr_idx_s;
        end else begin
            grant_s     = fix_grant_s;
            grant_idx_s = sel;
        end
    end

    // Grants only go to valid channels, so any grant is a transfer.
    assign grant_any_s = |grant_s;
    assign in_ready    = grant_s;

    // Output slot: reload on input transfer, empty on drain, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_r       <= SLOT_EMPTY;
            out_data_r   <= '0;
            out_ch_r     <= '0;
            last_grant_r <= SEL_W'(N_CH - 1);
        end else if (grant_any_s) begin
            slot_r       <= SLOT_FULL;
            out_data_r   <= in_data[32'(grant_idx_s)*WIDTH +: WIDTH];
            out_ch_r     <= grant_idx_s;
            last_grant_r <= grant_idx_s;
        end else if ((slot_r == SLOT_FULL) && out_ready) begin
            slot_r <= SLOT_EMPTY;
        end else begin
            slot_r <= slot_r;
        end
    end

    assign out_valid = (slot_r == SLOT_FULL);
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_mux_stream_rr.sv
// Self-checking bench for mux_stream_rr: directed scenarios plus randomized
// traffic checked against a behavioural model of the output slot.
module tb_mux_stream_rr;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [1:0]     sel;
    logic [W-1:0]   out_data;
    logic [1:0]     out_ch;
    logic           out_valid;
    logic           out_ready;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    bit       m_valid;
    logic [7:0] m_data;
    int       m_ch;
    int       m_last;

    mux_stream_rr #(.N_CH(N), .WIDTH(W), .SEL_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_grant();
        int s;
        if (rst || !(!m_valid || out_ready)) return -1;
        if (mode == 1'b0) begin
            s = int'(sel);
            if (s < N && in_valid[s]) return s;
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            s = (m_last + k) % N;
            if (in_valid[s]) return s;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        logic [N-1:0] one;
        one = 4'b0001;
        g = exp_grant();
        if (g < 0) return 4'b0000;
        return one << g;
    endfunction

    task automatic model_tick();
        int g;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_ch    = 0;
            m_last  = N - 1;
        end else begin
            g = exp_grant();
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[g*W +: W];
                m_ch    = g;
                m_last  = g;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic tick();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_chan_data();
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b1; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
        set_chan_data();
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready_hold got %b want 0000", in_ready); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
            checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
            checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch got %0d want 0", out_ch); end
        end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b want 0001", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h10) begin
            errors++; $display("FAIL reset_first_word got v=%b ch=%0d d=%h want v=1 ch=0 d=10", out_valid, out_ch, out_data);
        end
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = {8'h33, 8'hA5, 8'h11, 8'h00};
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_ready got %b want 0100", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 8'hA5) begin
            errors++; $display("FAIL fixed_word got v=%b ch=%0d d=%h want v=1 ch=2 d=a5", out_valid, out_ch, out_data);
        end
        sel = 2'd3; in_valid = 4'b0111;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL fixed_nogrant got %b want 0000", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_ch !== 2'd2 || out_data !== 8'hA5) begin
            errors++; $display("FAIL fixed_drain got v=%b ch=%0d d=%h want v=0 ch=2 d=a5", out_valid, out_ch, out_data);
        end
    endtask

    task automatic test_rr_fair();
        logic [N-1:0] one;
        one = 4'b0001;
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        set_chan_data();
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (in_ready !== (one << (i % 4))) begin errors++; $display("FAIL rr_fair_ready[%0d] got %b want %b", i, in_ready, one << (i % 4)); end
            tick();
            checks++; if (out_valid !== 1'b1 || int'(out_ch) != i % 4 || out_data !== 8'(8'h10 + i % 4)) begin
                errors++; $display("FAIL rr_fair_word[%0d] got v=%b ch=%0d d=%h want ch=%0d", i, out_valid, out_ch, out_data, i % 4);
            end
        end
    endtask

    task automatic test_rr_skip();
        int exp_seq [3] = '{3, 1, 3};
        in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ((in_ready & 4'b0101) !== 4'b0000 || !in_ready[exp_seq[i]]) begin
                errors++; $display("FAIL rr_skip_ready[%0d] got %b want ch %0d", i, in_ready, exp_seq[i]);
            end
            tick();
            checks++; if (int'(out_ch) != exp_seq[i] || out_valid !== 1'b1) begin
                errors++; $display("FAIL rr_skip_ch[%0d] got %0d want %0d", i, out_ch, exp_seq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0000", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 8'h13) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b ch=%0d d=%h want v=1 ch=3 d=13", i, out_valid, out_ch, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL bp_release_ready got %b want 0001", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h10) begin
            errors++; $display("FAIL bp_reload got v=%b ch=%0d d=%h want v=1 ch=0 d=10", out_valid, out_ch, out_data);
        end
    endtask

    task automatic test_mid_reset();
        tick();
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready got %b want 0000", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL midrst_restart got %b want 0001", in_ready); end
        tick();
        checks++; if (out_ch !== 2'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL midrst_ch got %0d want 0", out_ch); end
    endtask

    task automatic test_random();
        logic [N-1:0] er;
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 39) == 0);
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            #1;
            er = exp_ready();
            checks++; if (in_ready !== er) begin errors++; $display("FAIL rand_ready[%0d] got %b want %b", i, in_ready, er); end
            tick();
            checks++; if (out_valid !== m_valid || out_data !== m_data || int'(out_ch) != m_ch) begin
                errors++; $display("FAIL rand_out[%0d] got v=%b ch=%0d d=%h want v=%b ch=%0d d=%h",
                                   i, out_valid, out_ch, out_data, m_valid, m_ch, m_data);
            end
        end
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'b0000; out_ready = 1'b0; in_data = '0;
        m_valid = 1'b0; m_data = 8'h00; m_ch = 0; m_last = N - 1;
        @(posedge clk); #1;
        test_reset();
        test_fixed();
        test_rr_fair();
        test_rr_skip();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_stream_rr.md
Name: mux_stream_rr

Overview:
- Parametrised N-channel successor of the 4:1 select mux, for streaming data.
- Selects one of N_CH valid/ready input channels in one of two modes: fixed-select (external sel) or round-robin arbitration.
- Registers the winner into a single output slot with a valid/ready handshake.
- Sits between multiple producer streams and one consumer, e.g. merging lab datapaths onto one display or UART path.

Parameters:
- N_CH, 4, number of input channels (>=2).
- WIDTH, 8, data width per channel.
- SEL_W, 2, select/channel-index width; must equal ceil(log2(N_CH)).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready; at most one bit high per cycle.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  output slot holds data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_ch=0.
  - last_grant=N_CH-1, so channel 0 has first round-robin priority.
  - in_ready is forced to all-zero combinationally while rst=1.
- Slot states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Accept condition (combinational): accept = !out_valid | out_ready.
- Grant (combinational, only when accept=1):
  - mode=0: grant channel sel if in_valid[sel]=1; otherwise no grant. sel>=N_CH means no grant, ever.
  - mode=1: grant the first channel with in_valid=1, searching last_grant+1, last_grant+2, ... modulo N_CH. No valid channel means no grant.
- Handshake:
  - in_ready[g]=1 only for the granted channel g; all other bits are 0.
  - A transfer on channel g occurs when in_valid[g]&in_ready[g].
  - in_ready must not depend on any in_valid other than for selection (no combinational loop through in_ready).
- On input transfer, next edge: out_data<=in_data[g], out_ch<=g, out_valid<=1, last_grant<=g.
- Output transfer without simultaneous input transfer: out_valid<=0. out_data and out_ch hold their values.
- Simultaneous output drain and input transfer: slot reloads in the same edge; out_valid stays 1. Full throughput is one word per cycle.
- Back-pressure: while out_valid=1 and out_ready=0, out_data and out_ch are stable, and all in_ready bits are 0.
- Latency: 1 cycle from input transfer to out_valid.
- last_grant:
  - Updates only on input transfer, in both modes.
  - A mode switch takes effect on the next grant decision, with the pointer preserved.
- Wrap-around: after last_grant=N_CH-1, the search starts at channel 0.
- Reset mid-transfer: any pending word is discarded, and no in_ready is asserted during reset.

Decomposition:
- Shared include/package file holds:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - Default N_CH/WIDTH/SEL_W constants.
  - Helper function for the ceil-log2 check.
- One natural sub-module, rr_arbiter (N_CH, SEL_W):
  - Inputs: req[N_CH], ptr, enable.
  - Outputs: one-hot grant and encoded grant index.
  - Purely combinational; the pointer register lives in mux_stream_rr.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0. After release, mode=1 grants channel 0 first.
- Fixed select: mode=0, sel=2, in_valid=4'b1111, ch2 data=8'hA5, out_ready=1 -> only in_ready[2]=1; next cycle out_data=8'hA5, out_ch=2, out_valid=1. Set sel=3 with in_valid[3]=0 -> no grant, and out_valid drops after the drain.
- Round-robin fairness: mode=1, all four channels continuously valid, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 with one word per cycle.
- RR skipping: in_valid=4'b1010, last_grant=1 -> grant 3, then 1, then 3. Channels 0 and 2 are never granted.
- Back-pressure: out_valid=1, out_ready=0 for 5 cycles -> out_data and out_ch are constant and in_ready=0. On the cycle out_ready=1, the drain and reload happen together and out_valid stays 1.
- Mid-operation reset: assert rst while out_valid=1 and a grant is pending -> next cycle out_valid=0. Round-robin restarts at channel 0.
